four_bit_serial_subtractor: RTL
===============================

# four_bit_serial_subtractor

Bit-serial subtractor that computes D = A − B, LSB first, one bit per clock, using a single full-subtractor cell, a borrow flip-flop and shift registers. It is the inverse-operation companion to the team's serial adder: the same start/done handshake and operand-shift scheme, but it produces a difference, an unsigned borrow-out and a signed overflow flag. The block sits in the serial arithmetic datapath, where an upstream controller loads the operands with `start` and waits for `done`.

## Interface
- `N`, default 4: operand and result width. Legal values are N ≥ 2.
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Reset: asynchronous, active-high.
- `start`  in  1  Request. Operands are captured when `start` is sampled high in IDLE or DONE.
- `A`  in  N  Minuend. Sampled only on the accepting edge.
- `B`  in  N  Subtrahend. Sampled only on the accepting edge.
- `D`  out  N  Difference (registered). Holds the last result and updates only on completion.
- `borrow`  out  1  Unsigned borrow-out. 1 when A < B (unsigned).
- `ovf`  out  1  Signed (two's-complement) overflow of A − B.
- `busy`  out  1  High while in RUN.
- `done`  out  1  High in DONE. Held until the next accepted `start` or `rst`.

## Operation
- State machine: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when the bit counter reaches N−1 and the last bit is processed.
  - DONE → RUN on `start`.
  - DONE stays in DONE otherwise.
- Accept (start in IDLE or DONE):
  - shA ← A, shB ← B.
  - Internal difference shift register ← 0.
  - Borrow flip-flop br ← 0, counter ← 0.
  - `done` ← 0.
- RUN, each cycle, with a = shA[0], b = shB[0]:
  - Difference bit d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - The internal difference register shifts right with d inserted at the MSB.
  - shA and shB shift right with 0 filled in.
  - The counter increments.
- Completion (last RUN cycle, counter = N−1):
  - `borrow` ← br_next.
  - `ovf` ← br ^ br_next, i.e. borrow into the MSB XOR borrow out of the MSB.
  - `D` ← final difference, or its saturated value (see Configuration).
  - `done` ← 1.
- `start` while in RUN is ignored. Operands and progress are unaffected.
- A, B changing after the accepting edge have no effect.
- `D`, `borrow` and `ovf` do not change in RUN. They are stable from `done` rising until the next completion.
- Arithmetic is modulo 2^N, identical to A + ~B + 1 truncated to N bits.

## Timing
- Reset values (asynchronous, immediate): `D`=0, `borrow`=0, `ovf`=0, `busy`=0, `done`=0. State is IDLE, internal registers are 0.
- Start sampled at edge k:
  - `busy`=1 after edge k.
  - Bit i is computed in the cycle following edge k+i and registered at edge k+i+1.
  - After edge k+N: `busy`=0, `done`=1, and the results are valid.
  - Latency is exactly N cycles from the accepting edge to `done`.
- Back-to-back operation: `start` held high in DONE is accepted on the first DONE edge, so `done` is high for exactly 1 cycle. Throughput is one result per N+1 cycles.
- `rst` asserted mid-RUN aborts immediately. All outputs return to reset values, and the aborted result is never reported.
- `start` during `rst` is ignored. The first start edge after `rst` deasserts is accepted normally.

## Configuration
- `SERIAL_SUB_SAT_EN` defined: at completion, if the signed overflow is 1:
  - `D` ← 2^(N−1)−1 (max positive) when A[N−1]=0.
  - `D` ← 2^(N−1) (max negative) when A[N−1]=1.
  - `ovf` and `borrow` still report the raw conditions.
- `SERIAL_SUB_SAT_EN` undefined: `D` is always the wrapped modulo-2^N difference. No saturation logic is present.

## Test plan
- Reset, then N=4, A=0111, B=0011, start for 1 cycle → `done` exactly 4 cycles later; D=0100, borrow=0, ovf=0, `busy` high for those 4 cycles.
- A=0011, B=0111 → D=1100, borrow=1, ovf=0.
- A=0111, B=1000 → ovf=1, borrow=1. D=1111 without the macro, D=0111 with `SERIAL_SUB_SAT_EN`.
- A=1000, B=0001 → ovf=1, borrow=0. D=0111 without the macro, D=1000 with it.
- Pulse `start` again with A=1111, B=1111 in the 2nd RUN cycle of an ongoing 0111−0011 → ignored, D=0100 at `done`. Then start with `start` held high in DONE → `done` high 1 cycle, next D=0000.
- Assert `rst` at the 3rd RUN cycle → all outputs 0 immediately and no `done`. The next start with A=0101, B=0101 → D=0000 after 4 cycles.

Source files
------------

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial subtractor D = A - B, LSB first, one full-subtractor cell plus borrow flop.
// Optional saturation of D on signed overflow is enabled by defining SERIAL_SUB_SAT_EN.
module four_bit_serial_subtractor #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] D,
  output logic         borrow,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [N-1:0]    sha_q, shb_q, dif_q, d_q;
  logic [CntW-1:0] cnt_q;
  logic            br_q, borrow_q, ovf_q;

  logic            a_bit, b_bit, d_bit, br_next;
  logic            accept, last;
  logic [N-1:0]    diff_full, result;

  assign a_bit     = sha_q[0];
  assign b_bit     = shb_q[0];
  assign d_bit     = a_bit ^ b_bit ^ br_q;
  assign br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  assign diff_full = {d_bit, dif_q[N-1:1]};

  assign accept = start && (state_q != StRun);
  assign last   = (state_q == StRun) && (cnt_q == CntW'(N - 1));

`ifdef SERIAL_SUB_SAT_EN
  // On the last cycle a_bit is the minuend sign, which selects the saturation direction.
  always_comb begin
    result = diff_full;
    if (br_q ^ br_next) begin
      result = a_bit ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end
`else
  assign result = diff_full;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last)  state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sha_q    <= '0;
      shb_q    <= '0;
      dif_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      sha_q <= A;
      shb_q <= B;
      dif_q <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == StRun) begin
      sha_q <= sha_q >> 1;
      shb_q <= shb_q >> 1;
      dif_q <= diff_full;
      br_q  <= br_next;
      cnt_q <= cnt_q + CntW'(1);
      if (last) begin
        d_q      <= result;
        borrow_q <= br_next;
        ovf_q    <= br_q ^ br_next;
      end
    end
  end

  assign D      = d_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule
